// File: rtl/raiz_param_pkg.sv
// Shared definitions for the parametrised square-root core: FSM encoding and
// width helpers derived from the operand width.
package raiz_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH = 16;

    // Root width: one root bit per pair of operand bits.
    function automatic int unsigned half_w(input int unsigned width);
        return width / 2;
    endfunction

    // Iteration counter must hold values up to half_w - 1.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width / 2 + 1);
    endfunction

    localparam int unsigned DEF_HALF_W = half_w(DEF_WIDTH);
    localparam int unsigned DEF_CNT_W  = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/raiz_param_step.sv
// One restoring square-root iteration: shift two radicand bits into the partial
// remainder, trial-subtract (4R+1), and append the resulting root bit.
module raiz_param_step
    import raiz_param_pkg::*;
#(
    parameter  int unsigned WIDTH  = DEF_WIDTH,
    localparam int unsigned HALF_W = half_w(WIDTH),
    localparam int unsigned PW     = HALF_W + 2
) (
    input  logic [PW-1:0]     p_i,
    input  logic [HALF_W-1:0] r_i,
    input  logic [1:0]        a2_i,
    output logic [PW-1:0]     p_o,
    output logic [HALF_W-1:0] r_o
);

    logic [PW-1:0] p_shift;
    logic [PW-1:0] trial;
    logic [PW-1:0] diff;

    always_comb begin
        p_shift = PW'({p_i, a2_i});
        trial   = PW'({r_i, 2'b01});
        diff    = p_shift - trial;
        if (p_shift >= trial) begin
            p_o = diff;
            r_o = HALF_W'({r_i, 1'b1});
        end else begin
            p_o = p_shift;
            r_o = HALF_W'({r_i, 1'b0});
        end
    end

endmodule

// File: rtl/raiz_param.sv
// Sequential integer square root: floor root and remainder of a WIDTH-bit
// operand, one root bit per cycle, with optional round-to-nearest.
module raiz_param
    import raiz_param_pkg::*;
#(
    parameter  int unsigned WIDTH  = DEF_WIDTH,
    localparam int unsigned HALF_W = half_w(WIDTH),
    localparam int unsigned OW     = HALF_W + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             INIT,
    input  logic             ROUND,
    input  logic [WIDTH-1:0] OP_A,
    output logic             BUSY,
    output logic             DONE,
    output logic [OW-1:0]    RESULT,
    output logic [OW-1:0]    REM,
    output logic             EXACT
);

    localparam int unsigned PW = HALF_W + 2;
    localparam int unsigned CW = cnt_w(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [HALF_W-1:0] r_q, r_d;
    logic [PW-1:0]     p_q, p_d;
    logic [CW-1:0]     c_q, c_d;
    logic              round_q, round_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [OW-1:0]     result_q, result_d;
    logic [OW-1:0]     rem_q, rem_d;
    logic              exact_q, exact_d;

    logic [PW-1:0]     step_p;
    logic [HALF_W-1:0] step_r;

    raiz_param_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_i  (p_q),
        .r_i  (r_q),
        .a2_i (a_q[WIDTH-1 -: 2]),
        .p_o  (step_p),
        .r_o  (step_r)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            r_q      <= '0;
            p_q      <= '0;
            c_q      <= '0;
            round_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            exact_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            r_q      <= r_d;
            p_q      <= p_d;
            c_q      <= c_d;
            round_q  <= round_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            exact_q  <= exact_d;
        end
    end

    // BUSY stays high through the DONE cycle, which is spent back in IDLE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        r_d      = r_q;
        p_d      = p_q;
        c_d      = c_q;
        round_d  = round_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        rem_d    = rem_q;
        exact_d  = exact_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (INIT) begin
                    a_d     = OP_A;
                    r_d     = '0;
                    p_d     = '0;
                    c_d     = CW'(HALF_W - 1);
                    round_d = ROUND;
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                a_d = a_q << 2;
                p_d = step_p;
                r_d = step_r;
                if (c_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    c_d = c_q - CW'(1);
                end
            end
            ST_FIX: begin
                rem_d   = OW'(p_q);
                exact_d = (p_q == '0);
                // Remainder above the root means operand exceeds (R + 0.5)^2.
                if (round_q && (p_q > PW'(r_q))) begin
                    result_d = OW'(r_q) + OW'(1);
                end else begin
                    result_d = OW'(r_q);
                end
                done_d  = 1'b1;
                busy_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign REM    = rem_q;
    assign EXACT  = exact_q;

endmodule

// File: tb/tb_raiz_param.sv
// Directed and reference-model checks of raiz_param at WIDTH=16 and WIDTH=32.
module tb_raiz_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init16, round16, busy16, done16, exact16;
    logic [15:0] op16;
    logic [8:0]  res16, rem16;
    logic        init32, round32, busy32, done32, exact32;
    logic [31:0] op32;
    logic [16:0] res32, rem32;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    raiz_param #(.WIDTH(16)) dut16 (
        .CLK(clk), .RST_N(rst_n), .INIT(init16), .ROUND(round16), .OP_A(op16),
        .BUSY(busy16), .DONE(done16), .RESULT(res16), .REM(rem16), .EXACT(exact16)
    );

    raiz_param #(.WIDTH(32)) dut32 (
        .CLK(clk), .RST_N(rst_n), .INIT(init32), .ROUND(round32), .OP_A(op32),
        .BUSY(busy32), .DONE(done32), .RESULT(res32), .REM(rem32), .EXACT(exact32)
    );

    function automatic longint unsigned isqrt(input longint unsigned op, input int w);
        longint unsigned lo = 0;
        longint unsigned hi = 64'd1 << (w / 2);
        longint unsigned mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= op) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // Issue one operation (caller is 1 time unit after a rising edge) and wait for DONE.
    task automatic run_op(input bit w32, input logic [31:0] op, input bit rnd,
                          output logic [16:0] res, output logic [16:0] rem,
                          output logic ex, output int lat);
        if (w32) begin
            init32 = 1'b1; op32 = op; round32 = rnd;
        end else begin
            init16 = 1'b1; op16 = op[15:0]; round16 = rnd;
        end
        @(posedge clk); #1;
        init16 = 1'b0;
        init32 = 1'b0;
        lat = 0;
        res = '0;
        rem = '0;
        ex  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if ((w32 ? done32 : done16) === 1'b1) begin
                lat = k;
                res = w32 ? res32 : 17'(res16);
                rem = w32 ? rem32 : 17'(rem16);
                ex  = w32 ? exact32 : exact16;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy16 !== 1'b0) $display("FAIL reset_busy16: got %b expected 0", busy16); else passed++;
        checks++; if (done16 !== 1'b0) $display("FAIL reset_done16: got %b expected 0", done16); else passed++;
        checks++; if (res16 !== 9'd0) $display("FAIL reset_result16: got %0d expected 0", res16); else passed++;
        checks++; if (rem16 !== 9'd0) $display("FAIL reset_rem16: got %0d expected 0", rem16); else passed++;
        checks++; if (exact16 !== 1'b0) $display("FAIL reset_exact16: got %b expected 0", exact16); else passed++;
        checks++; if (busy32 !== 1'b0) $display("FAIL reset_busy32: got %b expected 0", busy32); else passed++;
        checks++; if (done32 !== 1'b0) $display("FAIL reset_done32: got %b expected 0", done32); else passed++;
        checks++; if (res32 !== 17'd0) $display("FAIL reset_result32: got %0d expected 0", res32); else passed++;
        checks++; if (rem32 !== 17'd0) $display("FAIL reset_rem32: got %0d expected 0", rem32); else passed++;
        checks++; if (exact32 !== 1'b0) $display("FAIL reset_exact32: got %b expected 0", exact32); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic16();
        logic [16:0] res, rem;
        logic ex;
        int lat;
        run_op(1'b0, 32'd144, 1'b0, res, rem, ex, lat);
        checks++; if (res !== 17'd12) $display("FAIL sq144_result: got %0d expected 12", res); else passed++;
        checks++; if (rem !== 17'd0) $display("FAIL sq144_rem: got %0d expected 0", rem); else passed++;
        checks++; if (ex !== 1'b1) $display("FAIL sq144_exact: got %b expected 1", ex); else passed++;
        checks++; if (lat !== 9) $display("FAIL sq144_latency: got %0d expected 9", lat); else passed++;
    endtask

    task automatic test_round16();
        logic [16:0] res, rem;
        logic ex;
        int lat;
        run_op(1'b0, 32'd157, 1'b1, res, rem, ex, lat);
        checks++; if (res !== 17'd13) $display("FAIL r157_result: got %0d expected 13", res); else passed++;
        checks++; if (rem !== 17'd13) $display("FAIL r157_rem: got %0d expected 13", rem); else passed++;
        checks++; if (ex !== 1'b0) $display("FAIL r157_exact: got %b expected 0", ex); else passed++;
        run_op(1'b0, 32'd150, 1'b1, res, rem, ex, lat);
        checks++; if (res !== 17'd12) $display("FAIL r150_result: got %0d expected 12", res); else passed++;
        checks++; if (rem !== 17'd6) $display("FAIL r150_rem: got %0d expected 6", rem); else passed++;
        checks++; if (ex !== 1'b0) $display("FAIL r150_exact: got %b expected 0", ex); else passed++;
    endtask

    task automatic test_edges16();
        logic [16:0] res, rem;
        logic ex;
        int lat;
        run_op(1'b0, 32'd0, 1'b0, res, rem, ex, lat);
        checks++; if (res !== 17'd0) $display("FAIL zero_result: got %0d expected 0", res); else passed++;
        checks++; if (rem !== 17'd0) $display("FAIL zero_rem: got %0d expected 0", rem); else passed++;
        checks++; if (ex !== 1'b1) $display("FAIL zero_exact: got %b expected 1", ex); else passed++;
        run_op(1'b0, 32'd65535, 1'b0, res, rem, ex, lat);
        checks++; if (res !== 17'd255) $display("FAIL max16_result: got %0d expected 255", res); else passed++;
        checks++; if (rem !== 17'd510) $display("FAIL max16_rem: got %0d expected 510", rem); else passed++;
        checks++; if (ex !== 1'b0) $display("FAIL max16_exact: got %b expected 0", ex); else passed++;
        run_op(1'b0, 32'd65535, 1'b1, res, rem, ex, lat);
        checks++; if (res !== 17'd256) $display("FAIL max16_round_result: got %0d expected 256", res); else passed++;
        checks++; if (rem !== 17'd510) $display("FAIL max16_round_rem: got %0d expected 510", rem); else passed++;
    endtask

    task automatic test_wide32();
        logic [16:0] res, rem;
        logic ex;
        int lat;
        run_op(1'b1, 32'hFFFF_FFFF, 1'b0, res, rem, ex, lat);
        checks++; if (res !== 17'd65535) $display("FAIL max32_result: got %0d expected 65535", res); else passed++;
        checks++; if (rem !== 17'd131070) $display("FAIL max32_rem: got %0d expected 131070", rem); else passed++;
        checks++; if (ex !== 1'b0) $display("FAIL max32_exact: got %b expected 0", ex); else passed++;
        checks++; if (lat !== 17) $display("FAIL max32_latency: got %0d expected 17", lat); else passed++;
        run_op(1'b1, 32'hFFFF_FFFF, 1'b1, res, rem, ex, lat);
        checks++; if (res !== 17'd65536) $display("FAIL max32_round_result: got %0d expected 65536", res); else passed++;
    endtask

    task automatic test_init_ignored();
        bit busy_ok = 1'b1;
        int lat = 0;
        init16 = 1'b1; op16 = 16'd144; round16 = 1'b0;
        @(posedge clk); #1;
        op16 = 16'd9999; round16 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 3) init16 = 1'b0;
            if (busy16 !== 1'b1) busy_ok = 1'b0;
            if (done16 === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++; if (!busy_ok) $display("FAIL ign_busy: got gap expected continuous high"); else passed++;
        checks++; if (lat !== 9) $display("FAIL ign_latency: got %0d expected 9", lat); else passed++;
        checks++; if (res16 !== 9'd12) $display("FAIL ign_result: got %0d expected 12", res16); else passed++;
        checks++; if (rem16 !== 9'd0) $display("FAIL ign_rem: got %0d expected 0", rem16); else passed++;
        @(posedge clk); #1;
        checks++; if (busy16 !== 1'b0) $display("FAIL ign_busy_after: got %b expected 0", busy16); else passed++;
    endtask

    task automatic test_back_to_back();
        bit busy_ok = 1'b1;
        int lat2 = 0;
        init16 = 1'b1; op16 = 16'd144; round16 = 1'b0;
        @(posedge clk); #1;
        op16 = 16'd157; round16 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (busy16 !== 1'b1) busy_ok = 1'b0;
            if (k == 9) begin
                checks++; if (done16 !== 1'b1) $display("FAIL b2b_done1: got %b expected 1", done16); else passed++;
                checks++; if (res16 !== 9'd12) $display("FAIL b2b_result1: got %0d expected 12", res16); else passed++;
            end
        end
        checks++; if (done16 !== 1'b0) $display("FAIL b2b_done_pulse: got %b expected 0", done16); else passed++;
        init16 = 1'b0;
        for (int k = 11; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done16 === 1'b1) begin
                lat2 = k;
                break;
            end
            if (busy16 !== 1'b1) busy_ok = 1'b0;
        end
        checks++; if (!busy_ok) $display("FAIL b2b_busy: got gap expected continuous high"); else passed++;
        checks++; if (lat2 !== 19) $display("FAIL b2b_done2_edge: got %0d expected 19", lat2); else passed++;
        checks++; if (res16 !== 9'd13) $display("FAIL b2b_result2: got %0d expected 13", res16); else passed++;
        checks++; if (rem16 !== 9'd13) $display("FAIL b2b_rem2: got %0d expected 13", rem16); else passed++;
    endtask

    task automatic test_reset_mid_calc();
        bit quiet = 1'b1;
        init16 = 1'b1; op16 = 16'd144; round16 = 1'b0;
        @(posedge clk); #1;
        init16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy16 !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy16); else passed++;
        checks++; if (done16 !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", done16); else passed++;
        checks++; if (res16 !== 9'd0) $display("FAIL rst_mid_result: got %0d expected 0", res16); else passed++;
        checks++; if (rem16 !== 9'd0) $display("FAIL rst_mid_rem: got %0d expected 0", rem16); else passed++;
        checks++; if (exact16 !== 1'b0) $display("FAIL rst_mid_exact: got %b expected 0", exact16); else passed++;
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done16 !== 1'b0 || busy16 !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) $display("FAIL rst_mid_no_done: got activity expected idle"); else passed++;
    endtask

    task automatic test_random();
        logic [16:0] res, rem;
        logic ex;
        int lat;
        logic [31:0] op;
        longint unsigned root, exp_rem, exp_res;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) begin
                op = (w == 1) ? $urandom : ($urandom & 32'h0000_FFFF);
                root = isqrt(longint'(op), (w == 1) ? 32 : 16);
                exp_rem = longint'(op) - root * root;
                exp_res = ((i % 2) == 1 && exp_rem > root) ? root + 1 : root;
                run_op(w == 1, op, (i % 2) == 1, res, rem, ex, lat);
                checks++; if (longint'(res) != exp_res || lat == 0)
                    $display("FAIL rand_result w%0d op=%0d: got %0d expected %0d", w, op, res, exp_res); else passed++;
                checks++; if (longint'(rem) != exp_rem)
                    $display("FAIL rand_rem w%0d op=%0d: got %0d expected %0d", w, op, rem, exp_rem); else passed++;
                checks++; if (ex !== (exp_rem == 0))
                    $display("FAIL rand_exact w%0d op=%0d: got %b expected %b", w, op, ex, exp_rem == 0); else passed++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        init16 = 1'b0; round16 = 1'b0; op16 = '0;
        init32 = 1'b0; round32 = 1'b0; op32 = '0;
        test_reset();
        test_basic16();
        test_round16();
        test_edges16();
        test_wide32();
        test_init_ignored();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/raiz_param.md
# raiz_param

Parametrised sequential integer square-root unit for the calculator datapath, successor to the fixed 16-bit root core. It computes floor(sqrt(OP_A)) and the remainder for an unsigned WIDTH-bit operand, one result bit per clock (restoring digit-by-digit method). It also offers optional round-to-nearest and an exact-square flag. Sits beside the other arithmetic cores behind the calculator's operation selector and uses the same INIT/DONE start-and-complete handshake.

## Interface
- WIDTH, 16, operand width in bits; even, 4..64
- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous, active-low reset
- INIT  in  1  start request; sampled only in IDLE
- ROUND  in  1  1 = round root to nearest, 0 = floor; sampled with INIT
- OP_A  in  WIDTH  unsigned radicand; sampled with INIT
- BUSY  out  1  high from accepted INIT until DONE cycle inclusive
- DONE  out  1  one-cycle pulse, result valid
- RESULT  out  WIDTH/2+1  root (extra MSB needed only for rounding carry)
- REM  out  WIDTH/2+1  OP_A − floor_root², always the floor remainder
- EXACT  out  1  REM == 0

## Operation
- Reset (RST_N low at an edge): state IDLE, BUSY=0, DONE=0, RESULT=0, REM=0, EXACT=0, internal registers cleared. Reset wins over all other inputs, including mid-computation; partial result discarded.
- States: IDLE → CALC → FIX → IDLE.
  - IDLE: on INIT=1 load operand shift register A=OP_A, root R=0, partial remainder P=0, count C=WIDTH/2−1, latch ROUND; go CALC.
  - CALC, each cycle: P' = (P<<2) | A[WIDTH−1:WIDTH−2]; A <<= 2; T = (R<<2)|1; if P' ≥ T then P=P'−T, R=(R<<1)|1 else P=P', R=R<<1. When C==0 go FIX, else C−1.
  - FIX: REM=P, EXACT=(P==0), RESULT = R+1 if latched ROUND and P > R, else R. DONE=1 for this following cycle; go IDLE.
- Width rules: P register WIDTH/2+2 bits (trial headroom); R WIDTH/2 bits; comparison and subtraction unsigned at WIDTH/2+2 bits. Rounding carry (OP_A ≥ (2^(WIDTH/2)−0.5)²) sets RESULT MSB; no saturation.
- RESULT/REM/EXACT hold their last values until the next FIX or reset; they do not change during CALC.
- INIT while BUSY: ignored, no queueing. INIT held high continuously: a new computation starts in the IDLE cycle right after DONE.
- OP_A/ROUND changes after acceptance have no effect.

## Timing
- Edge N samples INIT=1 in IDLE → BUSY high from after edge N.
- CALC occupies edges N+1..N+WIDTH/2; FIX evaluated at edge N+WIDTH/2+1; DONE and new outputs visible in the cycle after that edge (WIDTH=16: edge N+9).
- BUSY falls with DONE at edge N+WIDTH/2+2; earliest next acceptance is that same edge (throughput one result per WIDTH/2+2 cycles).
- Fixed latency independent of operand value.

## Structure
- Shared calculator package: FSM state encoding (IDLE, CALC, FIX) and localparams for half width and counter width ($clog2(WIDTH/2+1)).
- One natural sub-module: raiz_param_step, combinational single iteration (P, R, two operand bits → next P, R), parametrised by WIDTH; top holds FSM, counter and registers.

## Test plan
- WIDTH=16, OP_A=144, ROUND=0 → RESULT=12, REM=0, EXACT=1, DONE exactly 9 edges after INIT sample.
- WIDTH=16, OP_A=157, ROUND=1 → RESULT=13, REM=13, EXACT=0; OP_A=150, ROUND=1 → RESULT=12, REM=6.
- WIDTH=16, OP_A=0 → RESULT=0, REM=0, EXACT=1; OP_A=65535, ROUND=0 → RESULT=255, REM=510; ROUND=1 → RESULT=256.
- WIDTH=32, OP_A=0xFFFFFFFF → RESULT=65535, REM=131070, DONE 17 edges after INIT.
- INIT pulsed again and OP_A changed during CALC → ignored, first result unchanged, BUSY continuous; RST_N low mid-CALC → next cycle IDLE, all outputs 0, no DONE.
- Random OP_A sweep (both WIDTH values, both ROUND) vs reference model: RESULT² + REM relation and rounding rule hold for every result.
